mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 5: busy cycles for ops 0,1,4,5,6,7 (mult family).
REQ-002 Parameter DIV_LAT, default 10: busy cycles for ops 2,3 (div family).
REQ-003 clk  in  1  single clock; all state changes on posedge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 issue_valid  in  1  D-stage holds a mult/div-class instruction.
REQ-006 issue_op  in  4  op code: 0 multu, 1 mult, 2 divu, 3 div, 4 maddu, 5 madd, 6 msubu, 7 msub; 8-15 illegal.
REQ-007 issue_div0  in  1  divisor is zero; meaningful only with op 2/3.
REQ-008 hilo_acc  in  1  D-stage holds mfhi/mflo/mthi/mtlo.
REQ-009 flush  in  1  synchronous pipeline cancel.
REQ-010 start  out  1  combinational; datapath latches operands and op at this posedge.
REQ-011 start_op  out  4  op being started; equals issue_op when start=1, else 0.
REQ-012 busy  out  1  registered; operation in flight.
REQ-013 stall  out  1  combinational; freeze F/D stages this cycle.
REQ-014 commit  out  1  registered; HI/LO write enable from datapath result.
REQ-015 state  out  2  current FSM state, for debug.

Function
REQ-016 FSM states: IDLE=0, MUL=1, DIV=2; all other encodings unreachable and shall recover to IDLE.
REQ-017 Acceptance: in IDLE, start=1 when issue_valid=1, legal op, and flush=0.
REQ-018 On acceptance, next state is MUL or DIV per op family, with the counter loaded to MUL_LAT or DIV_LAT.
REQ-019 busy=1 in MUL/DIV; the counter decrements each cycle; the FSM returns to IDLE on the cycle after counter==1.
REQ-020 Mult timing: accepted at edge N -> busy high for cycles N+1..N+5; commit high in cycle N+5 only; IDLE from N+6.
REQ-021 commit=1 only in the last busy cycle (counter==1), except for suppressed div-by-zero.
REQ-022 Div-by-zero: a div/divu accepted with issue_div0=1 runs the full DIV_LAT; commit stays 0 (HI/LO unchanged).
REQ-023 stall = busy AND (issue_valid OR hilo_acc); this includes the commit cycle.
REQ-024 An issue stalled while busy is accepted in the first IDLE cycle; the back-to-back gap is one cycle.
REQ-025 Illegal op: no start, no stall, FSM stays IDLE.
REQ-026 Flush while busy: at the next posedge the FSM goes to IDLE, the counter clears, no commit occurs, and there is no residual stall.
REQ-027 Flush in IDLE with issue_valid: start=0, no acceptance.
REQ-028 Flush and counter==1 in the same cycle: commit still asserts that cycle (the write completes); IDLE next.
REQ-029 hilo_acc in IDLE: stall=0; mthi/mtlo writes are handled by the datapath, not this block.

Reset
REQ-030 reset low forces immediately: state=IDLE, counter=0, busy=0, commit=0.
REQ-031 While reset is low, start and stall are 0.
REQ-032 Reset mid-operation abandons the op with no commit.
REQ-033 Release is synchronous to the next posedge; the first acceptance is possible in the first cycle after release.

Structure
REQ-034 Shared package mdu_pkg holds: op code constants 0-7, IDLE/MUL/DIV encodings, MUL_LAT/DIV_LAT defaults, and an is_div(op) classification.
REQ-035 One sub-module, mdu_lat_counter: loadable 4-bit down-counter with load, value, and one output (counter==1).
REQ-036 The FSM, acceptance logic and stall logic reside in mdu_ctrl.

Verification
REQ-037 mult accepted at cycle 2 -> busy cycles 3-7, commit in cycle 7 only, state=IDLE at cycle 8.
REQ-038 div accepted, then mflo (hilo_acc=1) held in D -> stall=1 for all 10 busy cycles, stall=0 in the first IDLE cycle.
REQ-039 divu with issue_div0=1 -> busy for 10 cycles, commit never asserts.
REQ-040 madd accepted, flush pulsed in busy cycle 3 -> IDLE next cycle, commit never asserts; a following mult is accepted in the next cycle.
REQ-041 mult then immediate mult held in D -> second start in cycle N+6, second commit in cycle N+11.
REQ-042 reset driven low in busy cycle 4 of a div -> busy=0 immediately, no commit; issue_op=9 after release -> no start, no stall.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit controller:
// op codes, FSM encodings, default latencies and op classification.
package mdu_pkg;

    localparam logic [3:0] OP_MULTU = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_DIVU  = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_MADDU = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MSUBU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    // Codes 8-15 are illegal; only the top bit distinguishes them.
    function automatic logic is_legal(input logic [3:0] op);
        return ~op[3];
    endfunction

endpackage

// File: rtl/mdu_lat_counter.sv
// Loadable 4-bit down-counter tracking the remaining busy cycles of an op.
module mdu_lat_counter
    import mdu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       clear_i,
    input  logic       dec_i,
    input  logic [3:0] load_val_i,
    output logic [3:0] value_o,
    output logic       is_one_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 4'd0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o  = cnt_q;
    assign is_one_o = (cnt_q == 4'd1);

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit control: accepts mult/div ops from D, sequences the
// fixed latency, stalls dependent F/D traffic and raises the HI/LO commit.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  logic [3:0] issue_op,
    input  logic       issue_div0,
    input  logic       hilo_acc,
    input  logic       flush,
    output logic       start,
    output logic [3:0] start_op,
    output logic       busy,
    output logic       stall,
    output logic       commit,
    output logic [1:0] state
);

    localparam logic [3:0] MUL_LAT4 = MUL_LAT[3:0];
    localparam logic [3:0] DIV_LAT4 = DIV_LAT[3:0];

    mdu_state_e state_q, state_d;
    logic       busy_q, busy_d;
    logic       commit_q, commit_d;
    logic       sup_q, sup_d;

    logic       accept;
    logic       op_div;
    logic [3:0] lat_sel;
    logic       cnt_load, cnt_clear, cnt_dec;
    logic [3:0] cnt_val;
    logic       cnt_is_one;

    mdu_lat_counter u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .clear_i    (cnt_clear),
        .dec_i      (cnt_dec),
        .load_val_i (lat_sel),
        .value_o    (cnt_val),
        .is_one_o   (cnt_is_one)
    );

    // Reset gates acceptance so nothing starts while the block is held.
    assign op_div  = is_div(issue_op);
    assign lat_sel = op_div ? DIV_LAT4 : MUL_LAT4;
    assign accept  = reset && (state_q == ST_IDLE) && issue_valid
                     && is_legal(issue_op) && !flush;

    assign start    = accept;
    assign start_op = accept ? issue_op : 4'd0;
    assign stall    = reset && busy_q && (issue_valid || hilo_acc);
    assign busy     = busy_q;
    assign commit   = commit_q;
    assign state    = state_q;

    always_comb begin
        state_d   = state_q;
        sup_d     = sup_q;
        commit_d  = 1'b0;
        cnt_load  = 1'b0;
        cnt_clear = 1'b0;
        cnt_dec   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = op_div ? ST_DIV : ST_MUL;
                    cnt_load = 1'b1;
                    sup_d    = op_div && issue_div0;
                    commit_d = (lat_sel == 4'd1) && !(op_div && issue_div0);
                end
            end
            ST_MUL, ST_DIV: begin
                // A commit already registered for this cycle still completes under flush.
                if (flush || cnt_is_one) begin
                    state_d   = ST_IDLE;
                    cnt_clear = 1'b1;
                    sup_d     = 1'b0;
                end else begin
                    cnt_dec  = 1'b1;
                    commit_d = (cnt_val == 4'd2) && !sup_q;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_clear = 1'b1;
                sup_d     = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            commit_q <= 1'b0;
            sup_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            commit_q <= commit_d;
            sup_q    <= sup_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with a remaining-cycles reference model.
module tb_mdu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iv = 1'b0;
    logic [3:0] op = 4'd0;
    logic       d0 = 1'b0;
    logic       hilo = 1'b0;
    logic       fl = 1'b0;
    logic       start, busy, stall, commit;
    logic [3:0] start_op;
    logic [1:0] state;

    mdu_ctrl dut (
        .clk         (clk),
        .reset       (rst_n),
        .issue_valid (iv),
        .issue_op    (op),
        .issue_div0  (d0),
        .hilo_acc    (hilo),
        .flush       (fl),
        .start       (start),
        .start_op    (start_op),
        .busy        (busy),
        .stall       (stall),
        .commit      (commit),
        .state       (state)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Reference model: busy cycles left, div-by-zero suppression, op family.
    int m_rem = 0;
    bit m_sup = 1'b0;
    bit m_div = 1'b0;

    int cyc = 0;
    int start_tot = 0, busy_tot = 0, commit_tot = 0, stall_tot = 0;
    int start_cyc = 0, start_prev = 0, commit_cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic drv(input bit v, input int o, input bit z, input bit h, input bit f);
        iv = v; op = o[3:0]; d0 = z; hilo = h; fl = f;
    endtask

    task automatic tick();
        bit e_busy, e_commit, e_start, e_stall;
        int e_state, e_sop;
        @(negedge clk);
        e_busy   = (m_rem > 0);
        e_commit = (m_rem == 1) && !m_sup;
        e_start  = rst_n && !e_busy && iv && (op < 4'd8) && !fl;
        e_sop    = e_start ? int'(op) : 0;
        e_stall  = e_busy && (iv || hilo);
        e_state  = !e_busy ? 0 : (m_div ? 2 : 1);
        chk("start",    start,    e_start);
        chk("start_op", start_op, e_sop);
        chk("busy",     busy,     e_busy);
        chk("stall",    stall,    e_stall);
        chk("commit",   commit,   e_commit);
        chk("state",    state,    e_state);
        if (start)  begin start_tot++; start_prev = start_cyc; start_cyc = cyc; end
        if (busy)   busy_tot++;
        if (commit) begin commit_tot++; commit_cyc = cyc; end
        if (stall)  stall_tot++;
        @(posedge clk);
        if (rst_n) begin
            if (e_busy) begin
                m_rem = fl ? 0 : m_rem - 1;
            end else if (e_start) begin
                m_div = (op == 4'd2) || (op == 4'd3);
                m_rem = m_div ? 10 : 5;
                m_sup = m_div && d0;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drv(0, 0, 0, 0, 0);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, b0, c0, st0;
        #2;
        chk("rst_busy",   busy,   0);
        chk("rst_commit", commit, 0);
        chk("rst_state",  state,  0);
        drv(1, 1, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        idle(2);

        // Single mult: 5 busy cycles, commit in the last one.
        s0 = start_tot; b0 = busy_tot; c0 = commit_tot;
        drv(1, 0, 0, 0, 0); tick();
        idle(8);
        chk("mul_starts",  start_tot - s0, 1);
        chk("mul_busy",    busy_tot - b0, 5);
        chk("mul_commits", commit_tot - c0, 1);
        chk("mul_lat",     commit_cyc - start_cyc, 5);

        // div followed by mflo waiting in D.
        c0 = commit_tot; st0 = stall_tot;
        drv(1, 3, 0, 0, 0); tick();
        for (int i = 0; i < 11; i++) begin drv(0, 0, 0, 1, 0); tick(); end
        idle(2);
        chk("div_stalls",  stall_tot - st0, 10);
        chk("div_commits", commit_tot - c0, 1);
        chk("div_lat",     commit_cyc - start_cyc, 10);

        // divu by zero: full latency, no commit.
        b0 = busy_tot; c0 = commit_tot;
        drv(1, 2, 1, 0, 0); tick();
        idle(12);
        chk("div0_busy",    busy_tot - b0, 10);
        chk("div0_commits", commit_tot - c0, 0);

        // madd flushed in busy cycle 3, then a mult.
        s0 = start_tot; b0 = busy_tot; c0 = commit_tot;
        drv(1, 5, 0, 0, 0); tick();
        idle(2);
        drv(0, 0, 0, 0, 1); tick();
        drv(1, 1, 0, 0, 0); tick();
        idle(7);
        chk("flush_starts",  start_tot - s0, 2);
        chk("flush_busy",    busy_tot - b0, 8);
        chk("flush_commits", commit_tot - c0, 1);
        chk("flush_gap",     start_cyc - start_prev, 4);

        // Back-to-back mults with the second held in D.
        s0 = start_tot; c0 = commit_tot;
        for (int i = 0; i < 7; i++) begin drv(1, 1, 0, 0, 0); tick(); end
        idle(12);
        chk("b2b_starts",  start_tot - s0, 2);
        chk("b2b_gap",     start_cyc - start_prev, 6);
        chk("b2b_commit2", commit_cyc - start_prev, 11);
        chk("b2b_commits", commit_tot - c0, 2);

        // Flush coinciding with the commit cycle.
        b0 = busy_tot; c0 = commit_tot;
        drv(1, 0, 0, 0, 0); tick();
        idle(4);
        drv(0, 0, 0, 0, 1); tick();
        idle(2);
        chk("flush1_commits", commit_tot - c0, 1);
        chk("flush1_busy",    busy_tot - b0, 5);

        // Flush in IDLE, illegal ops, hilo access in IDLE.
        s0 = start_tot; st0 = stall_tot;
        drv(1, 1, 0, 0, 1); tick();
        drv(1, 12, 0, 0, 0); tick();
        drv(1, 15, 0, 0, 0); tick();
        drv(0, 0, 0, 1, 0); tick();
        idle(1);
        chk("idle_starts", start_tot - s0, 0);
        chk("idle_stalls", stall_tot - st0, 0);

        // Reset in busy cycle 4 of a div, then release.
        c0 = commit_tot;
        drv(1, 3, 0, 0, 0); tick();
        idle(3);
        drv(1, 1, 0, 0, 0);
        rst_n = 1'b0;
        m_rem = 0; m_sup = 1'b0; m_div = 1'b0;
        #1;
        chk("rst_mid_busy",   busy,   0);
        chk("rst_mid_commit", commit, 0);
        chk("rst_mid_start",  start,  0);
        chk("rst_mid_stall",  stall,  0);
        tick();
        tick();
        chk("rst_commits", commit_tot - c0, 0);
        rst_n = 1'b1;
        s0 = start_tot;
        drv(1, 1, 0, 0, 0); tick();
        chk("rel_start", start_tot - s0, 1);
        idle(6);
        s0 = start_tot; st0 = stall_tot;
        for (int i = 0; i < 3; i++) begin drv(1, 9, 0, 0, 0); tick(); end
        idle(1);
        chk("ill_starts", start_tot - s0, 0);
        chk("ill_stalls", stall_tot - st0, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
